// File: rtl/mmcm_lock_sequencer.sv
// MMCM bring-up controller: pulses the MMCM reset, qualifies LOCKED, then releases
// the 200/100/50 MHz domain resets in stages and restarts on loss of lock.
module mmcm_lock_sequencer #(
    parameter int unsigned RST_PULSE    = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned STAGE_GAP    = 8,
    parameter int unsigned MAX_RETRIES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked_in,
    input  logic       force_reset,
    output logic       mmcm_rst,
    output logic [2:0] rst_out,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned MAX_AB  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD  = (LOCK_STABLE > 2 * STAGE_GAP) ? LOCK_STABLE : 2 * STAGE_GAP;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(2 * STAGE_GAP - 1);
    localparam logic [CW-1:0] STAGE_TWO    = CW'(STAGE_GAP);

    typedef enum logic [2:0] {
        S_RESET_PULSE,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q;
    logic          locked_s;
    logic [7:0]    retry_q, retry_d, retry_inc;
    logic [7:0]    loss_q, loss_d;
    logic          mmcm_rst_q, mmcm_rst_d;
    logic [2:0]    rst_out_q, rst_out_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;

    assign locked_s  = sync_q[1];
    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (force_reset) begin
            state_d = S_RESET_PULSE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RESET_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (locked_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        if ((MAX_RETRIES != 0) && ({24'd0, retry_inc} == MAX_RETRIES)) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_RESET_PULSE;
                        end
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                    end
                end
                S_RELEASE: begin
                    if (!locked_s) begin
                        state_d = S_RESET_PULSE;
                        cnt_d   = '0;
                        retry_d = retry_inc;
                    end else if (cnt_q == RELEASE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                    if (!locked_s) begin
                        state_d = S_RESET_PULSE;
                        loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                    end
                end
                S_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = S_RESET_PULSE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        mmcm_rst_d = (state_d == S_RESET_PULSE) || (state_d == S_FAIL);
        ready_d    = (state_d == S_RUN);
        fail_d     = (state_d == S_FAIL);
        rst_out_d  = 3'b111;
        if (state_d == S_RUN) begin
            rst_out_d = 3'b000;
        end else if (state_d == S_RELEASE) begin
            rst_out_d = (cnt_d >= STAGE_TWO) ? 3'b100 : 3'b110;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET_PULSE;
            cnt_q      <= '0;
            sync_q     <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            mmcm_rst_q <= 1'b1;
            rst_out_q  <= 3'b111;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= {sync_q[0], locked_in};
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            mmcm_rst_q <= mmcm_rst_d;
            rst_out_q  <= rst_out_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign mmcm_rst      = mmcm_rst_q;
    assign rst_out       = rst_out_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Bench for mmcm_lock_sequencer: directed bring-up scenarios with literal expectations,
// then randomized lock/force activity checked every cycle against a phase/age model.
module tb_mmcm_lock_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 100;
    localparam int P_LS  = 10;
    localparam int P_GAP = 3;
    localparam int P_MAX = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked_in = 1'b0;
    logic       force_reset = 1'b0;
    logic       mmcm_rst;
    logic [2:0] rst_out;
    logic       ready;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mmcm_lock_sequencer #(
        .RST_PULSE   (P_RST),
        .LOCK_TIMEOUT(P_TO),
        .LOCK_STABLE (P_LS),
        .STAGE_GAP   (P_GAP),
        .MAX_RETRIES (P_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked_in    (locked_in),
        .force_reset  (force_reset),
        .mmcm_rst     (mmcm_rst),
        .rst_out      (rst_out),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    // Model: named phase plus cycles spent in it; locked_in seen through a two-sample history.
    string ph = "PULSE";
    string nx = "PULSE";
    int    age = 0;
    int    m_retry = 0;
    int    m_loss = 0;
    logic  m_s1 = 1'b0;
    logic  m_s2 = 1'b0;
    logic  ls;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ph = "PULSE"; age = 0; m_retry = 0; m_loss = 0;
                m_s1 = 1'b0; m_s2 = 1'b0; cyc = 0;
            end else begin
                cyc = cyc + 1;
                ls = m_s2;
                nx = ph;
                if (force_reset) begin
                    nx = "PULSE";
                    m_retry = 0;
                end else if (ph == "PULSE") begin
                    if (age == P_RST - 1) nx = "WAIT";
                end else if (ph == "WAIT") begin
                    if (ls) nx = "STABLE";
                    else if (age == P_TO - 1) begin
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                        nx = (P_MAX != 0 && m_retry == P_MAX) ? "FAIL" : "PULSE";
                    end
                end else if (ph == "STABLE") begin
                    if (!ls) nx = "WAIT";
                    else if (age == P_LS - 1) nx = "RELEASE";
                end else if (ph == "RELEASE") begin
                    if (!ls) begin
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                        nx = "PULSE";
                    end else if (age == 2 * P_GAP - 1) begin
                        nx = "RUN";
                        m_retry = 0;
                    end
                end else if (ph == "RUN") begin
                    if (!ls) begin
                        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                        nx = "PULSE";
                    end
                end
                age = (force_reset || nx != ph) ? 0 : age + 1;
                ph = nx;
                m_s2 = m_s1;
                m_s1 = locked_in;
            end
        end
    end

    function automatic int exp_rst_out();
        if (ph == "RUN") return 0;
        if (ph == "RELEASE") return (age >= P_GAP) ? 4 : 6;
        return 7;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("mdl_mmcm_rst", {31'd0, mmcm_rst}, (ph == "PULSE" || ph == "FAIL") ? 1 : 0);
            check("mdl_rst_out", {29'd0, rst_out}, exp_rst_out());
            check("mdl_ready", {31'd0, ready}, (ph == "RUN") ? 1 : 0);
            check("mdl_fail", {31'd0, fail}, (ph == "FAIL") ? 1 : 0);
            check("mdl_retry_cnt", {24'd0, retry_cnt}, m_retry);
            check("mdl_lock_loss_cnt", {24'd0, lock_loss_cnt}, m_loss);
        end
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 5000) begin
                checks++;
                errors++;
                $display("FAIL wait_cyc: cycle %0d, required %0d", cyc, n);
                break;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_mmcm_rst", {31'd0, mmcm_rst}, 1);
        check("rst_rst_out", {29'd0, rst_out}, 7);
        check("rst_ready", {31'd0, ready}, 0);
        check("rst_fail", {31'd0, fail}, 0);
        check("rst_retry", {24'd0, retry_cnt}, 0);
        check("rst_loss", {24'd0, lock_loss_cnt}, 0);
        rst_n = 1'b1;

        // Nominal bring-up, lock sampled from edge 20
        check("s1_c0_mmcm_rst", {31'd0, mmcm_rst}, 1);
        wait_cyc(3);  check("s1_c3_mmcm_rst", {31'd0, mmcm_rst}, 1);
        wait_cyc(4);  check("s1_c4_mmcm_rst", {31'd0, mmcm_rst}, 0);
        wait_cyc(19); locked_in = 1'b1;
        wait_cyc(31); check("s1_c31_rst_out", {29'd0, rst_out}, 7);
        wait_cyc(32); check("s1_c32_rst_out", {29'd0, rst_out}, 6);
        wait_cyc(34); check("s1_c34_rst_out", {29'd0, rst_out}, 6);
        wait_cyc(35); check("s1_c35_rst_out", {29'd0, rst_out}, 4);
        wait_cyc(37); check("s1_c37_ready", {31'd0, ready}, 0);
        wait_cyc(38); check("s1_c38_rst_out", {29'd0, rst_out}, 0);
        check("s1_c38_ready", {31'd0, ready}, 1);

        // Lock loss in RUN for 3 cycles
        wait_cyc(50); locked_in = 1'b0;
        wait_cyc(52); check("s4_c52_ready", {31'd0, ready}, 1);
        wait_cyc(53); locked_in = 1'b1;
        check("s4_c53_rst_out", {29'd0, rst_out}, 7);
        check("s4_c53_ready", {31'd0, ready}, 0);
        check("s4_c53_loss", {24'd0, lock_loss_cnt}, 1);
        check("s4_c53_mmcm_rst", {31'd0, mmcm_rst}, 1);
        wait_cyc(56); check("s4_c56_mmcm_rst", {31'd0, mmcm_rst}, 1);
        wait_cyc(57); check("s4_c57_mmcm_rst", {31'd0, mmcm_rst}, 0);
        wait_cyc(73); check("s4_c73_ready", {31'd0, ready}, 0);
        wait_cyc(74); check("s4_c74_ready", {31'd0, ready}, 1);
        check("s4_c74_retry", {24'd0, retry_cnt}, 0);

        // Force from RUN, then a glitchy lock
        wait_cyc(79); force_reset = 1'b1; locked_in = 1'b0;
        wait_cyc(80); force_reset = 1'b0;
        check("s3_c80_mmcm_rst", {31'd0, mmcm_rst}, 1);
        check("s3_c80_loss", {24'd0, lock_loss_cnt}, 1);
        wait_cyc(89); locked_in = 1'b1;
        wait_cyc(94); locked_in = 1'b0;
        wait_cyc(95); locked_in = 1'b1;
        wait_cyc(107); check("s3_c107_rst_out", {29'd0, rst_out}, 7);
        wait_cyc(108); check("s3_c108_rst_out", {29'd0, rst_out}, 6);
        check("s3_c108_retry", {24'd0, retry_cnt}, 0);
        wait_cyc(114); check("s3_c114_ready", {31'd0, ready}, 1);

        // Timeout twice into FAIL
        wait_cyc(129); force_reset = 1'b1; locked_in = 1'b0;
        wait_cyc(130); force_reset = 1'b0;
        wait_cyc(233); check("s2_c233_retry", {24'd0, retry_cnt}, 0);
        check("s2_c233_mmcm_rst", {31'd0, mmcm_rst}, 0);
        wait_cyc(234); check("s2_c234_retry", {24'd0, retry_cnt}, 1);
        check("s2_c234_mmcm_rst", {31'd0, mmcm_rst}, 1);
        wait_cyc(237); check("s2_c237_mmcm_rst", {31'd0, mmcm_rst}, 1);
        wait_cyc(238); check("s2_c238_mmcm_rst", {31'd0, mmcm_rst}, 0);
        wait_cyc(337); check("s2_c337_fail", {31'd0, fail}, 0);
        wait_cyc(338); check("s2_c338_fail", {31'd0, fail}, 1);
        check("s2_c338_retry", {24'd0, retry_cnt}, 2);
        check("s2_c338_mmcm_rst", {31'd0, mmcm_rst}, 1);
        check("s2_c338_rst_out", {29'd0, rst_out}, 7);
        wait_cyc(360); check("s2_c360_fail", {31'd0, fail}, 1);

        // Recovery from FAIL
        wait_cyc(369); force_reset = 1'b1; locked_in = 1'b1;
        wait_cyc(370); force_reset = 1'b0;
        check("s5_c370_fail", {31'd0, fail}, 0);
        check("s5_c370_retry", {24'd0, retry_cnt}, 0);
        check("s5_c370_mmcm_rst", {31'd0, mmcm_rst}, 1);
        wait_cyc(390); check("s5_c390_ready", {31'd0, ready}, 0);
        wait_cyc(391); check("s5_c391_ready", {31'd0, ready}, 1);

        // Async reset at RELEASE r=2
        wait_cyc(399); force_reset = 1'b1;
        wait_cyc(400); force_reset = 1'b0;
        wait_cyc(417); check("s6_c417_rst_out", {29'd0, rst_out}, 6);
        #2 rst_n = 1'b0;
        #1;
        check("s6_async_rst_out", {29'd0, rst_out}, 7);
        check("s6_async_mmcm_rst", {31'd0, mmcm_rst}, 1);
        check("s6_async_ready", {31'd0, ready}, 0);
        check("s6_async_loss", {24'd0, lock_loss_cnt}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized lock activity with occasional force_reset
        for (int i = 0; i < 40; i++) begin
            int len;
            locked_in = 1'($urandom_range(0, 1));
            len = locked_in ? $urandom_range(1, 60) : $urandom_range(1, 250);
            for (int j = 0; j < len; j++) begin
                force_reset = ($urandom_range(0, 149) == 0);
                @(posedge clk);
                #1;
            end
        end
        force_reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmcm_lock_sequencer.md
Name: mmcm_lock_sequencer

Overview:
- Controller on the other end of the MMCM clock generator. It drives the MMCM reset and consumes its LOCKED output.
- Pulses the MMCM reset, waits for lock with a timeout and retry limit, and qualifies lock as stable. It then releases three staged, active-high domain resets in order: 200, 100, 50 MHz domains.
- Monitors lock in operation and restarts the sequence on loss of lock.
- Runs on the free-running board clock. It is instantiated beside the clock generator in the top level.

Parameters:
- RST_PULSE, 16: cycles mmcm_rst is held high per attempt (must be >=1).
- LOCK_TIMEOUT, 65536: maximum cycles in WAIT_LOCK before a retry.
- LOCK_STABLE, 256: consecutive synchronized-locked cycles required before release.
- STAGE_GAP, 8: cycles between successive domain reset releases (must be >=1).
- MAX_RETRIES, 8: failed attempts before entering FAIL; 0 means retry forever.

Ports:
- clk, input, 1: free-running reference clock.
- rst_n, input, 1: asynchronous, active-low reset.
- locked_in, input, 1: MMCM LOCKED. Asynchronous to clk.
- force_reset, input, 1: synchronous single-cycle request to restart the sequence.
- mmcm_rst, output, 1: active-high reset to the MMCM RST pin.
- rst_out, output, 3: active-high domain resets. Bit 0 is the 200 MHz domain, bit 1 the 100 MHz domain, bit 2 the 50 MHz domain.
- ready, output, 1: high only in RUN.
- fail, output, 1: high only in FAIL.
- retry_cnt, output, 8: failed attempts since the last RUN or force_reset. Saturates at 255.
- lock_loss_cnt, output, 8: lock losses seen in RUN. Saturates at 255. Cleared only by rst_n.

Behaviour:
- Reset state while rst_n=0, and the first cycle after release:
  - state=RESET_PULSE, counter=0;
  - mmcm_rst=1, rst_out=3'b111;
  - ready=0, fail=0;
  - retry_cnt=0, lock_loss_cnt=0;
  - synchronizer flops=0.
- Output timing: all outputs are registered. Outputs reflect the current state and counter; there is no combinational input-to-output path.
- Synchronizer: locked_in passes through two flops to form locked_s, adding 2 cycles of latency. Only locked_s is used internally.
- RESET_PULSE:
  - mmcm_rst=1, rst_out=111.
  - Lasts exactly RST_PULSE cycles, then goes to WAIT_LOCK with counter=0.
- WAIT_LOCK:
  - mmcm_rst=0, rst_out=111.
  - If locked_s=1, go to STABLE with counter=0.
  - Otherwise, at counter=LOCK_TIMEOUT-1, increment retry_cnt.
  - After that increment, go to FAIL if MAX_RETRIES!=0 and the new retry_cnt equals MAX_RETRIES; otherwise go to RESET_PULSE.
  - If locked_s=1 and the timeout occur on the same cycle, lock wins.
- STABLE:
  - mmcm_rst=0, rst_out=111.
  - Any cycle with locked_s=0 returns to WAIT_LOCK with the counter cleared; this is not counted as a retry.
  - After LOCK_STABLE consecutive cycles with locked_s=1, go to RELEASE with counter=0.
- RELEASE, lasting 2*STAGE_GAP cycles with r = cycle index from 0:
  - rst_out[0]=0 for all r;
  - rst_out[1]=0 for r>=STAGE_GAP;
  - rst_out[2]=1 throughout.
  - locked_s=0 at any point: rst_out=111 on the next edge, go to RESET_PULSE, and increment retry_cnt.
- RUN:
  - rst_out=000, ready=1; retry_cnt is cleared on entry.
  - locked_s=0: go to RESET_PULSE with rst_out=111 and ready=0 on the next edge, and increment lock_loss_cnt (saturating).
- FAIL:
  - mmcm_rst=1, rst_out=111, fail=1.
  - Exits only via force_reset or rst_n.
- force_reset:
  - Accepted in any state and takes priority over all other transitions.
  - Next state is RESET_PULSE with counter=0 and retry_cnt=0; fail=0 and rst_out=111.
  - A force_reset asserted in the cycle before RUN entry prevents RUN.
- Counter width is ceil(log2(max(RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE, 2*STAGE_GAP)))+1; the counter never wraps.
- rst_n asserted mid-sequence forces the reset values immediately, asynchronously.

Test Plan:
All scenarios use RST_PULSE=4, LOCK_TIMEOUT=100, LOCK_STABLE=10, STAGE_GAP=3, MAX_RETRIES=2.
1. Nominal bring-up: release rst_n, locked_in=1 from cycle 20.
   - mmcm_rst is high for cycles 0-3.
   - locked_s rises at cycle 22; STABLE covers cycles 22-31.
   - rst_out goes 110 at cycle 32 and 100 at cycle 35; 000 with ready=1 at cycle 38.
2. Timeout to FAIL: locked_in=0 throughout.
   - retry_cnt=1 after the first 100-cycle WAIT_LOCK, followed by a second 4-cycle mmcm_rst pulse.
   - After the second timeout, retry_cnt=2, fail=1, mmcm_rst=1 held, rst_out=111.
3. Glitchy lock: locked_in high for 5 cycles, low for 1, then high.
   - STABLE restarts; no retry is counted.
   - Release begins 10 cycles after the final locked_s rise.
4. Lock loss in RUN: drop locked_in for 3 cycles.
   - 3 cycles after the drop: rst_out=111, ready=0, lock_loss_cnt=1, and a new 4-cycle mmcm_rst pulse.
   - Full re-sequence to RUN; retry_cnt=0.
5. Recovery: in FAIL, pulse force_reset.
   - Next cycle: fail=0, retry_cnt=0, mmcm_rst=1.
   - With locked_in=1, the block reaches RUN.
6. Async reset mid-RELEASE: assert rst_n=0 at r=2.
   - Immediately: rst_out=111, mmcm_rst=1, ready=0, lock_loss_cnt=0.
